// File: rtl/fp_addsub_req_ctrl_if.sv
// Request/response and add/sub-unit signal bundle for fp_addsub_req_ctrl.
// slave is the controller's view; master is the requester/add-sub-unit side.
interface fp_addsub_req_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [4:0]  req_tag;
   logic        au_opcode;
   logic        au_sign1;
   logic        au_sign2;
   logic [7:0]  au_exp1;
   logic [7:0]  au_exp2;
   logic [22:0] au_sig1;
   logic [22:0] au_sig2;
   logic [31:0] au_fp_out;
   logic [2:0]  au_err;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic [2:0]  rsp_err;
   logic [4:0]  rsp_tag;
   logic [2:0]  flags;
   logic        clr_flags;

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_tag,
      input  au_fp_out, au_err, rsp_ready, clr_flags,
      output req_ready, au_opcode, au_sign1, au_sign2, au_exp1, au_exp2,
      output au_sig1, au_sig2, rsp_valid, rsp_result, rsp_err, rsp_tag, flags
   );

   modport master (
      output req_valid, req_op, req_a, req_b, req_tag,
      output au_fp_out, au_err, rsp_ready, clr_flags,
      input  req_ready, au_opcode, au_sign1, au_sign2, au_exp1, au_exp2,
      input  au_sig1, au_sig2, rsp_valid, rsp_result, rsp_err, rsp_tag, flags
   );
endinterface

// File: rtl/fp_addsub_req_ctrl.sv
// Sequences one request at a time through an external FP add/sub unit: holds
// unpacked operands for LATENCY cycles, captures the result, and presents a response.
module fp_addsub_req_ctrl #(
   parameter int unsigned LATENCY = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   fp_addsub_req_ctrl_if.slave bus
);

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [4:0]  tag_q, tag_d;
   logic [31:0] res_q, res_d;
   logic [2:0]  err_q, err_d;
   logic [4:0]  rtag_q, rtag_d;
   logic [2:0]  flags_q, flags_d;
   logic        ready_c;
   logic        accept_c;
   logic        capture_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         tag_q   <= '0;
         res_q   <= '0;
         err_q   <= '0;
         rtag_q  <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         tag_q   <= tag_d;
         res_q   <= res_d;
         err_q   <= err_d;
         rtag_q  <= rtag_d;
         flags_q <= flags_d;
      end
   end

   always_comb begin
      ready_c   = (state_q == IDLE) | ((state_q == RESP) & bus.rsp_ready);
      accept_c  = bus.req_valid & ready_c;
      capture_c = (state_q == EXEC) & (cnt_q == '0);

      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      tag_d   = tag_q;
      res_d   = res_q;
      err_d   = err_q;
      rtag_d  = rtag_q;

      unique case (state_q)
         IDLE: if (accept_c) state_d = EXEC;
         EXEC: begin
            if (capture_c) state_d = RESP;
            else           cnt_d   = cnt_q - 4'd1;
         end
         RESP: if (bus.rsp_ready) state_d = accept_c ? EXEC : IDLE;
         default: state_d = IDLE;
      endcase

      if (accept_c) begin
         op_d  = bus.req_op;
         a_d   = bus.req_a;
         b_d   = bus.req_b;
         tag_d = bus.req_tag;
         cnt_d = CNT_INIT;
      end

      if (capture_c) begin
         res_d  = bus.au_fp_out;
         err_d  = bus.au_err;
         rtag_d = tag_q;
      end

      // Clear applies first so error bits captured on the same edge survive.
      flags_d = bus.clr_flags ? '0 : flags_q;
      if (capture_c) flags_d = flags_d | bus.au_err;
   end

   assign bus.req_ready  = ready_c;
   assign bus.au_opcode  = op_q;
   assign bus.au_sign1   = a_q[31];
   assign bus.au_exp1    = a_q[30:23];
   assign bus.au_sig1    = a_q[22:0];
   assign bus.au_sign2   = b_q[31];
   assign bus.au_exp2    = b_q[30:23];
   assign bus.au_sig2    = b_q[22:0];
   assign bus.rsp_valid  = (state_q == RESP);
   assign bus.rsp_result = res_q;
   assign bus.rsp_err    = err_q;
   assign bus.rsp_tag    = rtag_q;
   assign bus.flags      = flags_q;

endmodule

// File: tb/tb_fp_addsub_req_ctrl.sv
// Directed bench for fp_addsub_req_ctrl at LATENCY 1, 3 and 4, with a lookup-table
// stand-in for the add/sub unit holding hand-computed IEEE-754 results.
module tb_fp_addsub_req_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic rst4_n = 1'b1;
   always #5 clk = ~clk;

   fp_addsub_req_ctrl_if if1 ();
   fp_addsub_req_ctrl_if if3 ();
   fp_addsub_req_ctrl_if if4 ();

   logic [2:0]  err1, err3, err4;
   logic [31:0] au1_a, au1_b, au3_a, au3_b, au4_a, au4_b;
   logic [2:0]  flags_exp;
   int total = 0;
   int bad = 0;

   fp_addsub_req_ctrl #(.LATENCY(1)) u_dut1 (.clk(clk), .rst_n(rst_n),  .bus(if1));
   fp_addsub_req_ctrl #(.LATENCY(3)) u_dut3 (.clk(clk), .rst_n(rst_n),  .bus(if3));
   fp_addsub_req_ctrl #(.LATENCY(4)) u_dut4 (.clk(clk), .rst_n(rst4_n), .bus(if4));

   function automatic logic [31:0] fp_ref(input logic op, input logic [31:0] a,
                                          input logic [31:0] b);
      case ({op, a, b})
         {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000; // 1 + 2
         {1'b1, 32'h40400000, 32'h3F800000}: return 32'h40000000; // 3 - 1
         {1'b0, 32'h40000000, 32'h40000000}: return 32'h40800000; // 2 + 2
         {1'b0, 32'h3FC00000, 32'h3F000000}: return 32'h40000000; // 1.5 + 0.5
         {1'b0, 32'hBF800000, 32'h3F800000}: return 32'h00000000; // -1 + 1
         {1'b1, 32'h3F800000, 32'h40000000}: return 32'hBF800000; // 1 - 2
         {1'b1, 32'h41200000, 32'h3F000000}: return 32'h41180000; // 10 - 0.5
         {1'b0, 32'h7F800000, 32'h3F800000}: return 32'h7F800000; // inf + 1
         {1'b1, 32'h7F800000, 32'h7F800000}: return 32'h7FC00000; // inf - inf
         default:                            return 32'hDEADBEEF;
      endcase
   endfunction

   assign au1_a = {if1.au_sign1, if1.au_exp1, if1.au_sig1};
   assign au1_b = {if1.au_sign2, if1.au_exp2, if1.au_sig2};
   assign au3_a = {if3.au_sign1, if3.au_exp1, if3.au_sig1};
   assign au3_b = {if3.au_sign2, if3.au_exp2, if3.au_sig2};
   assign au4_a = {if4.au_sign1, if4.au_exp1, if4.au_sig1};
   assign au4_b = {if4.au_sign2, if4.au_exp2, if4.au_sig2};
   assign if1.au_fp_out = fp_ref(if1.au_opcode, au1_a, au1_b);
   assign if3.au_fp_out = fp_ref(if3.au_opcode, au3_a, au3_b);
   assign if4.au_fp_out = fp_ref(if4.au_opcode, au4_a, au4_b);
   assign if1.au_err = err1;
   assign if3.au_err = err3;
   assign if4.au_err = err4;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  tag;
      logic [2:0]  err;
      logic [31:0] res;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One full LATENCY=1 transaction on DUT1; entered and left at posedge+1.
   task automatic run1(input vec_t v, input logic clr);
      chk("idle_ready", 32'(if1.req_ready), 32'd1);
      if1.req_valid = 1'b1;
      if1.req_op    = v.op;
      if1.req_a     = v.a;
      if1.req_b     = v.b;
      if1.req_tag   = v.tag;
      err1          = v.err;
      @(posedge clk); #1;
      if1.req_valid = 1'b0;
      if1.req_a     = 32'hFFFFFFFF;
      if1.req_b     = 32'hFFFFFFFF;
      if1.req_op    = ~v.op;
      if1.req_tag   = ~v.tag;
      if1.rsp_ready = 1'b1;
      if1.clr_flags = clr;
      @(negedge clk);
      chk("exec_ready", 32'(if1.req_ready), 32'd0);
      chk("exec_valid", 32'(if1.rsp_valid), 32'd0);
      chk("au_a", au1_a, v.a);
      chk("au_b", au1_b, v.b);
      chk("au_op", 32'(if1.au_opcode), 32'(v.op));
      @(posedge clk); #1;
      if1.rsp_ready = 1'b0;
      if1.clr_flags = 1'b0;
      flags_exp = (clr ? 3'b000 : flags_exp) | v.err;
      @(negedge clk);
      chk("rsp_valid", 32'(if1.rsp_valid), 32'd1);
      chk("rsp_result", if1.rsp_result, v.res);
      chk("rsp_err", 32'(if1.rsp_err), 32'(v.err));
      chk("rsp_tag", 32'(if1.rsp_tag), 32'(v.tag));
      chk("flags", 32'(if1.flags), 32'(flags_exp));
      chk("resp_ready_hold", 32'(if1.req_ready), 32'd0);
      @(posedge clk); #1;
      if1.rsp_ready = 1'b1;
      @(negedge clk);
      chk("resp_ready_go", 32'(if1.req_ready), 32'd1);
      @(posedge clk); #1;
      if1.rsp_ready = 1'b0;
      @(negedge clk);
      chk("done_valid", 32'(if1.rsp_valid), 32'd0);
      chk("done_ready", 32'(if1.req_ready), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      logic seen;
      vecs[0] = '{1'b0, 32'h3F800000, 32'h40000000, 5'd5,  3'b000, 32'h40400000};
      vecs[1] = '{1'b1, 32'h40400000, 32'h3F800000, 5'd9,  3'b000, 32'h40000000};
      vecs[2] = '{1'b0, 32'h40000000, 32'h40000000, 5'd31, 3'b000, 32'h40800000};
      vecs[3] = '{1'b0, 32'h3FC00000, 32'h3F000000, 5'd0,  3'b000, 32'h40000000};
      vecs[4] = '{1'b0, 32'hBF800000, 32'h3F800000, 5'd17, 3'b000, 32'h00000000};
      vecs[5] = '{1'b1, 32'h3F800000, 32'h40000000, 5'd12, 3'b000, 32'hBF800000};
      vecs[6] = '{1'b1, 32'h41200000, 32'h3F000000, 5'd3,  3'b000, 32'h41180000};
      vecs[7] = '{1'b0, 32'h7F800000, 32'h3F800000, 5'd22, 3'b001, 32'h7F800000};
      vecs[8] = '{1'b1, 32'h7F800000, 32'h7F800000, 5'd30, 3'b100, 32'h7FC00000};

      if1.req_valid = 1'b0; if1.req_op = 1'b0; if1.req_a = '0; if1.req_b = '0;
      if1.req_tag = '0; if1.rsp_ready = 1'b0; if1.clr_flags = 1'b0;
      if3.req_valid = 1'b0; if3.req_op = 1'b0; if3.req_a = '0; if3.req_b = '0;
      if3.req_tag = '0; if3.rsp_ready = 1'b0; if3.clr_flags = 1'b0;
      if4.req_valid = 1'b0; if4.req_op = 1'b0; if4.req_a = '0; if4.req_b = '0;
      if4.req_tag = '0; if4.rsp_ready = 1'b0; if4.clr_flags = 1'b0;
      err1 = '0; err3 = '0; err4 = '0;
      flags_exp = '0;

      #1 rst_n = 1'b0; rst4_n = 1'b0;
      #1;
      chk("rst_valid", 32'(if1.rsp_valid), 32'd0);
      chk("rst_result", if1.rsp_result, 32'd0);
      chk("rst_err_tag_flags", {21'd0, if1.rsp_err, if1.rsp_tag, if1.flags}, 32'd0);
      chk("rst_au_a", au1_a, 32'd0);
      chk("rst_au_b", au1_b, 32'd0);
      chk("rst_au_op", 32'(if1.au_opcode), 32'd0);
      #10 rst_n = 1'b1; rst4_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(if1.req_ready), 32'd1);
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) run1(vecs[i], 1'b0);

      // Sticky flags and coincident clear on DUT1
      if1.clr_flags = 1'b1;
      @(posedge clk); #1;
      if1.clr_flags = 1'b0;
      flags_exp = '0;
      @(negedge clk);
      chk("flags_cleared", 32'(if1.flags), 32'd0);
      @(posedge clk); #1;
      v = vecs[0]; v.err = 3'b010; run1(v, 1'b0);
      v = vecs[1]; v.err = 3'b001; run1(v, 1'b0);
      chk("flags_sticky", 32'(if1.flags), 32'b011);
      v = vecs[2]; v.err = 3'b000; run1(v, 1'b0);
      v = vecs[3]; v.err = 3'b100; run1(v, 1'b1);
      chk("flags_clr_capture", 32'(if1.flags), 32'b100);

      // LATENCY=3: operand hold, backpressure, back-to-back accept on DUT3
      if3.req_valid = 1'b1; if3.req_op = 1'b1; if3.req_a = 32'h40400000;
      if3.req_b = 32'h3F800000; if3.req_tag = 5'd7;
      @(posedge clk); #1;
      if3.req_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c < 3) begin
            chk("l3_valid_low", 32'(if3.rsp_valid), 32'd0);
            chk("l3_au_a", au3_a, 32'h40400000);
            chk("l3_au_b", au3_b, 32'h3F800000);
            chk("l3_au_op", 32'(if3.au_opcode), 32'd1);
         end else begin
            chk("l3_valid", 32'(if3.rsp_valid), 32'd1);
            chk("l3_result", if3.rsp_result, 32'h40000000);
         end
      end
      if3.req_valid = 1'b1; if3.req_op = 1'b0; if3.req_a = 32'h3F800000;
      if3.req_b = 32'h40000000; if3.req_tag = 5'd8;
      err3 = 3'b111;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_valid", 32'(if3.rsp_valid), 32'd1);
         chk("bp_result", if3.rsp_result, 32'h40000000);
         chk("bp_err_tag", {24'd0, if3.rsp_err, if3.rsp_tag}, {24'd0, 3'b000, 5'd7});
         chk("bp_ready", 32'(if3.req_ready), 32'd0);
         chk("bp_au_a", au3_a, 32'h40400000);
      end
      err3 = 3'b000;
      if3.rsp_ready = 1'b1;
      #1 chk("b2b_ready", 32'(if3.req_ready), 32'd1);
      @(posedge clk); #1;
      if3.rsp_ready = 1'b0;
      if3.req_op = 1'b1; if3.req_a = 32'h41200000; if3.req_b = 32'h41200000;
      if3.req_tag = 5'd9;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c < 3) begin
            chk("b2b_exec_valid", 32'(if3.rsp_valid), 32'd0);
            chk("b2b_exec_ready", 32'(if3.req_ready), 32'd0);
            chk("b2b_au_a", au3_a, 32'h3F800000);
            chk("b2b_au_b", au3_b, 32'h40000000);
            chk("b2b_au_op", 32'(if3.au_opcode), 32'd0);
         end else begin
            chk("b2b_valid", 32'(if3.rsp_valid), 32'd1);
            chk("b2b_result", if3.rsp_result, 32'h40400000);
            chk("b2b_tag", 32'(if3.rsp_tag), 32'd8);
         end
      end
      if3.req_valid = 1'b0;
      if3.rsp_ready = 1'b1;
      @(posedge clk); #1;
      if3.rsp_ready = 1'b0;
      @(negedge clk);
      chk("l3_done_valid", 32'(if3.rsp_valid), 32'd0);
      chk("l3_done_ready", 32'(if3.req_ready), 32'd1);
      chk("l3_flags", 32'(if3.flags), 32'd0);
      @(posedge clk); #1;

      // LATENCY=4 on DUT4, then reset mid-EXEC
      if4.req_valid = 1'b1; if4.req_op = 1'b0; if4.req_a = 32'h3F800000;
      if4.req_b = 32'h40000000; if4.req_tag = 5'd2; err4 = 3'b101;
      @(posedge clk); #1;
      if4.req_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("l4_valid", 32'(if4.rsp_valid), (c == 4) ? 32'd1 : 32'd0);
      end
      chk("l4_result", if4.rsp_result, 32'h40400000);
      chk("l4_flags", 32'(if4.flags), 32'b101);
      if4.rsp_ready = 1'b1;
      @(posedge clk); #1;
      if4.rsp_ready = 1'b0;
      if4.req_valid = 1'b1; if4.req_op = 1'b1; if4.req_a = 32'h40400000;
      if4.req_b = 32'h3F800000; if4.req_tag = 5'd21; err4 = 3'b000;
      @(posedge clk); #1;
      if4.req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      chk("l4_pre_rst_au", au4_a, 32'h40400000);
      #1 rst4_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(if4.rsp_valid), 32'd0);
      chk("mid_rst_result", if4.rsp_result, 32'd0);
      chk("mid_rst_err_tag_flags", {21'd0, if4.rsp_err, if4.rsp_tag, if4.flags}, 32'd0);
      chk("mid_rst_au_a", au4_a, 32'd0);
      chk("mid_rst_au_b", au4_b, 32'd0);
      chk("mid_rst_au_op", 32'(if4.au_opcode), 32'd0);
      @(posedge clk);
      @(posedge clk); #2;
      rst4_n = 1'b1;
      if4.rsp_ready = 1'b1;
      @(negedge clk);
      chk("rel_ready", 32'(if4.req_ready), 32'd1);
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         seen = seen | if4.rsp_valid;
      end
      chk("rel_no_rsp", 32'(seen), 32'd0);
      chk("rel_flags", 32'(if4.flags), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_addsub_req_ctrl.md
FP_ADDSUB_REQ_CTRL -- requirements
Module: fp_addsub_req_ctrl

Interface
REQ-001 SHALL have parameter: LATENCY, default 1, number of cycles the add/sub datapath operands are held before the result is sampled (legal 1..15).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_op  in  1  0 add, 1 subtract.
- req_a, req_b  in  32  IEEE-754 single operands.
- req_tag  in  5  requester ID, returned unchanged.
- au_opcode  out  1  to add/sub unit opcode.
- au_sign1, au_sign2  out  1  unpacked signs.
- au_exp1, au_exp2  out  8  unpacked exponents.
- au_sig1, au_sig2  out  23  unpacked significands.
- au_fp_out  in  32  add/sub unit result.
- au_err  in  3  add/sub unit error code.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_result  out  32  captured result.
- rsp_err  out  3  captured error code.
- rsp_tag  out  5  tag of the request.
- flags  out  3  sticky OR of all captured error codes.
- clr_flags  in  1  synchronous clear of flags.

Function
REQ-003 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-004 SHALL drive req_ready = (state==IDLE) | (state==RESP & rsp_ready).
REQ-005 SHALL, on clock edge with req_valid & req_ready, register op, a, b, tag; enter EXEC; load cycle counter (4 bits) with LATENCY-1.
REQ-006 SHALL drive au_* from registers only: au_sign=a[31], au_exp=a[30:23], au_sig=a[22:0] (same for b); values stable for the entire EXEC period and unchanged until next accept.
REQ-007 SHALL, in EXEC, decrement counter each cycle; on the edge where counter==0, capture au_fp_out into rsp_result, au_err into rsp_err, enter RESP.
REQ-008 Latency: rsp_valid SHALL rise exactly LATENCY cycles after the accepting edge.
REQ-009 SHALL assert rsp_valid only in RESP; rsp_result/rsp_err/rsp_tag held stable while rsp_valid & !rsp_ready.
REQ-010 SHALL, in RESP with rsp_ready: go to EXEC if req_valid (back-to-back accept, no bubble), else IDLE.
REQ-011 SHALL ignore req_valid while in EXEC (req_ready low, no state change).
REQ-012 SHALL update flags on the capture edge: flags <= flags | au_err.
REQ-013 SHALL clear flags on clr_flags; clr_flags coincident with capture SHALL yield flags = au_err (new bits survive).
REQ-014 SHALL ignore rsp_ready when rsp_valid is low.
REQ-015 SHALL produce one and only one response per accepted request, in acceptance order.

Reset
REQ-016 SHALL, on rst_n low (async), force state IDLE, counter 0, rsp_valid 0, rsp_result 0, rsp_err 0, rsp_tag 0, flags 0, all au_* outputs 0.
REQ-017 SHALL discard any in-flight request on reset mid-EXEC or mid-RESP; no response after release.
REQ-018 SHALL have req_ready high on the first cycle after rst_n deasserts.

Verification
REQ-019 Add, LATENCY=1: a=0x3F800000, b=0x40000000, op=0, tag=5 -> rsp_valid 1 cycle after accept, rsp_result=0x40400000, rsp_err=0, rsp_tag=5.
REQ-020 Sub, LATENCY=3: a=0x40400000, b=0x3F800000, op=1 -> au_* stable 3 cycles, rsp_valid 3 cycles after accept, rsp_result=0x40000000.
REQ-021 Backpressure: rsp_ready low 5 cycles with req_valid held high -> rsp_* stable, req_ready 0; rsp_ready high -> next request accepted same edge, no idle cycle.
REQ-022 Sticky flags (stub au_err): capture 3'b010 then 3'b001 -> flags=3'b011; clr_flags coincident with capture of 3'b100 -> flags=3'b100.
REQ-023 Reset mid-EXEC (LATENCY=4, rst_n low at cycle 2) -> all outputs 0 immediately, no rsp_valid after release, req_ready 1 first cycle after release.
